// File: rtl/strict_priority_arbiter.sv
// Strict-priority arbiter for NUM_CLIENTS requesters with programmable priorities,
// a grant/acknowledge handshake with the server and age-based anti-starvation promotion.
module strict_priority_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int PRIO_W      = 2,
  parameter int AGE_W       = 4,
  parameter int AGE_LIMIT   = 8,
  localparam int ADDR_W     = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS*PRIO_W-1:0] client_priority,
  input  logic [NUM_CLIENTS-1:0]        client_rq,
  input  logic                          server_ack,
  output logic                          grant_valid,
  output logic [ADDR_W-1:0]             address_to_be_served,
  output logic [NUM_CLIENTS-1:0]        grant_onehot,
  output logic                          aged_grant
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]        state;
  logic [AGE_W-1:0]  age [NUM_CLIENTS];

  logic              aged_hit;
  logic [ADDR_W-1:0] aged_idx;
  logic              prio_found;
  logic [PRIO_W-1:0] best_prio;
  logic [ADDR_W-1:0] best_idx;
  logic [ADDR_W-1:0] win_idx;

  // Winner selection: a starved client (lowest index first) pre-empts the priority
  // search; otherwise the strict '<' keeps the lowest index on priority ties.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path
    // can leave a variable unassigned and infer a latch.
    aged_hit   = 1'b0;
    aged_idx   = '0;
    prio_found = 1'b0;
    best_prio  = '1;
    best_idx   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      // NOTE: blocking '=' here so later iterations see the updated running minimum;
      // state registers below use '<=' so all flops update together on the edge.
      if ((AGE_LIMIT != 0) && client_rq[i] && !aged_hit &&
          (age[i] == AGE_W'(AGE_LIMIT))) begin
        aged_hit = 1'b1;
        aged_idx = ADDR_W'(i);
      end
      if (client_rq[i] &&
          (!prio_found || (client_priority[i*PRIO_W +: PRIO_W] < best_prio))) begin
        prio_found = 1'b1;
        best_prio  = client_priority[i*PRIO_W +: PRIO_W];
        best_idx   = ADDR_W'(i);
      end
    end
    win_idx = aged_hit ? aged_idx : best_idx;
  end

  assign grant_valid = (state == GRANT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                <= IDLE;
      address_to_be_served <= '0;
      grant_onehot         <= '0;
      aged_grant           <= 1'b0;
      // NOTE: the age counters are state that steers arbitration, so this small
      // register array is reset explicitly rather than left to power-up values.
      for (int i = 0; i < NUM_CLIENTS; i++) age[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|client_rq) begin
            state                <= GRANT;
            address_to_be_served <= win_idx;
            grant_onehot         <= NUM_CLIENTS'(1) << win_idx;
            aged_grant           <= aged_hit;
            // Ages move only on the decision edge; losers saturate at AGE_LIMIT.
            for (int i = 0; i < NUM_CLIENTS; i++) begin
              if (ADDR_W'(i) == win_idx || !client_rq[i])
                age[i] <= '0;
              else if (age[i] < AGE_W'(AGE_LIMIT))
                age[i] <= age[i] + 1'b1;
            end
          end
        end
        GRANT: begin
          if (server_ack) begin
            state        <= IDLE;
            grant_onehot <= '0;
            aged_grant   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strict_priority_arbiter.sv
// Self-checking bench for strict_priority_arbiter: a cycle model feeds a scoreboard of
// expected grants, plus directed checks of the reference scenarios.
module tb_strict_priority_arbiter;

  localparam int N      = 4;
  localparam int PW     = 2;
  localparam int LIMIT  = 2;

  typedef struct {
    int       addr;
    logic [N-1:0] onehot;
    logic     aged;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N*PW-1:0] client_priority;
  logic [N-1:0]  client_rq;
  logic          server_ack;
  logic          grant_valid;
  logic [1:0]    address_to_be_served;
  logic [N-1:0]  grant_onehot;
  logic          aged_grant;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];
  exp_t cur;
  logic m_grant = 1'b0;
  int   m_addr  = 0;
  int   m_age [N] = '{default: 0};
  logic prev_valid = 1'b0;

  strict_priority_arbiter #(
    .NUM_CLIENTS(N), .PRIO_W(PW), .AGE_W(4), .AGE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .client_priority(client_priority),
    .client_rq(client_rq), .server_ack(server_ack), .grant_valid(grant_valid),
    .address_to_be_served(address_to_be_served), .grant_onehot(grant_onehot),
    .aged_grant(aged_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference pick: starved clients first, then scan priority levels from 0 upward.
  function automatic exp_t model_pick(input logic [N-1:0] rq, input logic [N*PW-1:0] pr);
    exp_t r;
    r.addr = -1;
    r.aged = 1'b0;
    for (int i = 0; i < N; i++)
      if (r.addr < 0 && rq[i] && m_age[i] == LIMIT) begin
        r.addr = i;
        r.aged = 1'b1;
      end
    for (int p = 0; p < (1 << PW); p++)
      for (int i = 0; i < N; i++)
        if (r.addr < 0 && rq[i] && int'(pr[i*PW +: PW]) == p) r.addr = i;
    r.onehot = '0;
    r.onehot[r.addr] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t w;
    if (!reset_n) begin
      m_grant <= 1'b0;
      m_addr  <= 0;
      for (int i = 0; i < N; i++) m_age[i] <= 0;
      exp_q.delete();
    end else if (!m_grant) begin
      if (|client_rq) begin
        w = model_pick(client_rq, client_priority);
        exp_q.push_back(w);
        m_grant <= 1'b1;
        m_addr  <= w.addr;
        for (int i = 0; i < N; i++)
          if (i == w.addr || !client_rq[i]) m_age[i] <= 0;
          else m_age[i] <= (m_age[i] + 1 > LIMIT) ? LIMIT : m_age[i] + 1;
      end
    end else if (server_ack) begin
      m_grant <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("valid", grant_valid, m_grant);
    check("addr", address_to_be_served, m_addr);
    if (!grant_valid) check("onehot_idle", grant_onehot, 0);
    if (grant_valid && !prev_valid) begin
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("sb_onehot", grant_onehot, cur.onehot);
        check("sb_aged", aged_grant, cur.aged);
      end
    end else if (grant_valid) begin
      check("stable_onehot", grant_onehot, cur.onehot);
      check("stable_aged", aged_grant, cur.aged);
    end
    prev_valid <= grant_valid;
  end

  task automatic wait_grant();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant_valid) break;
    end
    check("grant_seen", grant_valid, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic release_grant();
    server_ack = 1'b1;
    client_rq  = '0;
    @(negedge clk);
    server_ack = 1'b0;
  endtask

  initial begin
    int exp_addr [4];
    logic exp_aged [4];
    exp_addr = '{0, 0, 3, 0};
    exp_aged = '{1'b0, 1'b0, 1'b1, 1'b0};

    reset_n         = 1'b0;
    client_rq       = 4'b1111;
    client_priority = '0;
    server_ack      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", grant_valid, 0);
    check("rst_onehot", grant_onehot, 0);
    check("rst_addr", address_to_be_served, 0);
    check("rst_aged", aged_grant, 0);

    // Basic selection: c0=3 c1=2 c2=0 c3=1, all requesting.
    client_priority = {2'd1, 2'd0, 2'd2, 2'd3};
    reset_n = 1'b1;
    @(negedge clk);
    check("basic_valid", grant_valid, 1);
    check("basic_addr", address_to_be_served, 2);
    check("basic_onehot", grant_onehot, 4'b0100);
    repeat (4) @(negedge clk);
    check("basic_hold", address_to_be_served, 2);
    server_ack = 1'b1;
    @(negedge clk);
    server_ack = 1'b0;
    client_rq  = '0;
    check("basic_ack_valid", grant_valid, 0);
    @(negedge clk);

    // Tie-break: c1 and c3 both priority 0.
    do_reset();
    client_priority = {2'd0, 2'd3, 2'd0, 2'd3};
    client_rq = 4'b1010;
    wait_grant();
    check("tie_addr", address_to_be_served, 1);
    check("tie_onehot", grant_onehot, 4'b0010);
    release_grant();

    // Grant hold: c3 granted, then drops while high-priority c0 raises.
    do_reset();
    client_priority = {2'd3, 2'd0, 2'd0, 2'd0};
    client_rq = 4'b1000;
    wait_grant();
    check("hold_addr", address_to_be_served, 3);
    client_rq = 4'b0001;
    repeat (3) @(negedge clk);
    check("hold_still", address_to_be_served, 3);
    server_ack = 1'b1;
    @(negedge clk);
    server_ack = 1'b0;
    check("hold_gap", grant_valid, 0);
    @(negedge clk);
    check("hold_next_valid", grant_valid, 1);
    check("hold_next_addr", address_to_be_served, 0);
    release_grant();

    // Starvation: c0 prio 0 and c3 prio 3 requesting continuously.
    do_reset();
    client_priority = {2'd3, 2'd1, 2'd1, 2'd0};
    client_rq = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_grant();
      check($sformatf("starve_addr%0d", k), address_to_be_served, exp_addr[k]);
      check($sformatf("starve_aged%0d", k), aged_grant, exp_aged[k]);
      server_ack = 1'b1;
      @(negedge clk);
      server_ack = 1'b0;
    end

    // Reset mid-grant: c3 is at the aging limit before the reset.
    wait_grant();
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", grant_valid, 0);
    check("midrst_onehot", grant_onehot, 0);
    check("midrst_addr", address_to_be_served, 0);
    check("midrst_aged", aged_grant, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_grant();
      check($sformatf("post_rst_addr%0d", k), address_to_be_served, 0);
      check($sformatf("post_rst_aged%0d", k), aged_grant, 0);
      server_ack = 1'b1;
      @(negedge clk);
      server_ack = 1'b0;
    end
    release_grant();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
